uart_tx_ctrl: RTL and testbench

- Control and datapath stage of the UART transmitter. It sits directly upstream of the Tx output mux.
- Accepts a parallel byte with a valid strobe and sequences the frame: start, data bits LSB-first, optional parity, stop.
- Drives the mux select, the serial data bit and the parity bit. The mux registers the line, so TX_OUT follows mux_sel/ser_data/par_bit by one CLK.
- CLK is the Tx baud-rate clock: one state = one bit period.

---
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control/datapath: sequences start, LSB-first data, optional
// parity and stop, driving the Tx output mux select, serial data and parity bit.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_reg;
  logic                  par_en_reg;

  // mux_sel and busy are registered alongside the state they decode,
  // so each branch assigns the values belonging to the state it enters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      data_reg   <= '0;
      bit_cnt    <= '0;
      par_reg    <= 1'b0;
      par_en_reg <= 1'b0;
      mux_sel    <= SEL_STOP;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            data_reg   <= P_DATA;
            par_en_reg <= PAR_EN;
            par_reg    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            bit_cnt    <= '0;
            state      <= START;
            mux_sel    <= SEL_START;
            busy       <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          mux_sel <= SEL_DATA;
          busy    <= 1'b1;
        end
        DATA: begin
          busy <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_reg) begin
              state   <= PARITY;
              mux_sel <= SEL_PARITY;
            end else begin
              state   <= STOP;
              mux_sel <= SEL_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          state   <= STOP;
          mux_sel <= SEL_STOP;
          busy    <= 1'b1;
        end
        STOP: begin
          state   <= IDLE;
          mux_sel <= SEL_STOP;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          mux_sel <= SEL_STOP;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ser_data = data_reg[0];
    if (state == DATA) ser_data = data_reg[bit_cnt];
  end

  assign par_bit = par_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random frames compared cycle by cycle
// against an expected frame built from the framing rules.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  int passed = 0;
  int total  = 0;

  logic [1:0] exp_mux[$];
  logic       exp_ser[$];

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected line-control sequence of one frame, one entry per busy cycle.
  task automatic build_model(input logic [W-1:0] d, input logic pen);
    exp_mux.delete();
    exp_ser.delete();
    exp_mux.push_back(2'b00); exp_ser.push_back(d[0]);
    for (int i = 0; i < W; i++) begin
      exp_mux.push_back(2'b10); exp_ser.push_back(d[i]);
    end
    if (pen) begin
      exp_mux.push_back(2'b11); exp_ser.push_back(d[0]);
    end
    exp_mux.push_back(2'b01); exp_ser.push_back(d[0]);
  endtask

  function automatic logic parity_of(input logic [W-1:0] d, input logic typ);
    return (($countones(d) + int'(typ)) % 2) == 1;
  endfunction

  task automatic test_reset();
    RST = 1'b1; DATA_VALID = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) RST = 1'b0;
      tick();
      total++;
      if ({mux_sel, busy, par_bit, ser_data} !== 5'b01_0_0_0)
        $display("FAIL reset_idle cyc%0d: got mux=%b busy=%b par=%b ser=%b, expected mux=01 busy=0 par=0 ser=0",
                 i, mux_sel, busy, par_bit, ser_data);
      else passed++;
    end
  endtask

  task automatic test_frame(input logic [W-1:0] d, input logic pen, input logic typ, input string name);
    logic ep;
    build_model(d, pen);
    ep = parity_of(d, typ);
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 0; i < exp_mux.size(); i++) begin
      total++;
      if ({mux_sel, ser_data, busy, par_bit} !== {exp_mux[i], exp_ser[i], 1'b1, ep})
        $display("FAIL %s cyc%0d: got mux=%b ser=%b busy=%b par=%b, expected mux=%b ser=%b busy=1 par=%b",
                 name, i, mux_sel, ser_data, busy, par_bit, exp_mux[i], exp_ser[i], ep);
      else passed++;
      P_DATA = W'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      tick();
    end
    total++;
    if ({mux_sel, busy, ser_data, par_bit} !== {2'b01, 1'b0, d[0], ep})
      $display("FAIL %s end_idle: got mux=%b busy=%b ser=%b par=%b, expected mux=01 busy=0 ser=%b par=%b",
               name, mux_sel, busy, ser_data, par_bit, d[0], ep);
    else passed++;
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] d = 8'hA5;
    logic ep;
    build_model(d, 1'b1);
    ep = parity_of(d, 1'b0);
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    for (int i = 0; i < exp_mux.size(); i++) begin
      total++;
      if ({mux_sel, ser_data, busy, par_bit} !== {exp_mux[i], exp_ser[i], 1'b1, ep})
        $display("FAIL ignore_busy cyc%0d: got mux=%b ser=%b busy=%b par=%b, expected mux=%b ser=%b busy=1 par=%b",
                 i, mux_sel, ser_data, busy, par_bit, exp_mux[i], exp_ser[i], ep);
      else passed++;
      // strobe during the 3rd DATA cycle and during STOP
      if (i == 3 || i == exp_mux.size() - 1) begin
        DATA_VALID = 1'b1; P_DATA = 8'h3C;
      end else begin
        DATA_VALID = 1'b0;
      end
      tick();
    end
    DATA_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({mux_sel, busy, ser_data, par_bit} !== {2'b01, 1'b0, d[0], ep})
        $display("FAIL ignore_busy idle%0d: got mux=%b busy=%b ser=%b par=%b, expected mux=01 busy=0 ser=%b par=%b",
                 k, mux_sel, busy, ser_data, par_bit, d[0], ep);
      else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1 = 8'h01;
    logic [W-1:0] d2 = 8'h80;
    logic ep1, ep2;
    ep1 = parity_of(d1, 1'b0);
    ep2 = parity_of(d2, 1'b0);
    build_model(d1, 1'b1);
    P_DATA = d1; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    P_DATA = d2;
    for (int i = 0; i < exp_mux.size(); i++) begin
      total++;
      if ({mux_sel, ser_data, busy, par_bit} !== {exp_mux[i], exp_ser[i], 1'b1, ep1})
        $display("FAIL b2b_first cyc%0d: got mux=%b ser=%b busy=%b par=%b, expected mux=%b ser=%b busy=1 par=%b",
                 i, mux_sel, ser_data, busy, par_bit, exp_mux[i], exp_ser[i], ep1);
      else passed++;
      tick();
    end
    total++;
    if ({mux_sel, busy} !== 3'b01_0)
      $display("FAIL b2b_gap: got mux=%b busy=%b, expected mux=01 busy=0", mux_sel, busy);
    else passed++;
    tick();
    DATA_VALID = 1'b0;
    build_model(d2, 1'b1);
    for (int i = 0; i < exp_mux.size(); i++) begin
      total++;
      if ({mux_sel, ser_data, busy, par_bit} !== {exp_mux[i], exp_ser[i], 1'b1, ep2})
        $display("FAIL b2b_second cyc%0d: got mux=%b ser=%b busy=%b par=%b, expected mux=%b ser=%b busy=1 par=%b",
                 i, mux_sel, ser_data, busy, par_bit, exp_mux[i], exp_ser[i], ep2);
      else passed++;
      tick();
    end
    total++;
    if ({mux_sel, busy} !== 3'b01_0)
      $display("FAIL b2b_end: got mux=%b busy=%b, expected mux=01 busy=0", mux_sel, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] d = 8'hFF;
    logic ep;
    build_model(d, 1'b1);
    ep = parity_of(d, 1'b0);
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      total++;
      if ({mux_sel, ser_data, busy, par_bit} !== {exp_mux[i], exp_ser[i], 1'b1, ep})
        $display("FAIL rst_mid pre cyc%0d: got mux=%b ser=%b busy=%b par=%b, expected mux=%b ser=%b busy=1 par=%b",
                 i, mux_sel, ser_data, busy, par_bit, exp_mux[i], exp_ser[i], ep);
      else passed++;
      if (i < 4) tick();
    end
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h55;
    tick();
    RST = 1'b0; DATA_VALID = 1'b0;
    total++;
    if ({mux_sel, busy, par_bit, ser_data} !== 5'b01_0_0_0)
      $display("FAIL rst_mid abort: got mux=%b busy=%b par=%b ser=%b, expected mux=01 busy=0 par=0 ser=0",
               mux_sel, busy, par_bit, ser_data);
    else passed++;
    tick();
    total++;
    if ({mux_sel, busy} !== 3'b01_0)
      $display("FAIL rst_mid idle: got mux=%b busy=%b, expected mux=01 busy=0", mux_sel, busy);
    else passed++;
    test_frame(8'h55, 1'b1, 1'b1, "rst_mid_refill");
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 10; n++)
      test_frame(W'($urandom), 1'($urandom), 1'($urandom), "random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame(8'hA5, 1'b1, 1'b0, "even_parity");
    test_frame(8'hA5, 1'b1, 1'b1, "odd_parity");
    test_frame(8'h3C, 1'b0, 1'b0, "no_parity");
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
